cdb_arbiter: RTL



---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle between completing functional units and the CDB arbiter: the per-FU
// result handshake, the pipeline flush and the registered CDB broadcast.
interface cdb_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic                    flush_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*TAG_W-1:0]  req_tag_i;
  logic [N_REQ*DATA_W-1:0] req_value_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    cdb_valid_o;
  logic [TAG_W-1:0]        cdb_tag_o;
  logic [DATA_W-1:0]       cdb_value_o;
  logic [SRC_W-1:0]        cdb_src_o;

  modport master (
    output flush_i, req_valid_i, req_tag_i, req_value_i,
    input  req_ready_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_src_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_tag_i, req_value_i,
    output req_ready_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding slot per functional unit, one grant per
// cycle, broadcast as a registered {tag, value, src} on the common data bus.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SrcW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  slot_valid_q, slot_valid_d;
  logic [TAG_W-1:0]  slot_tag_q   [N_REQ];
  logic [DATA_W-1:0] slot_value_q [N_REQ];
  logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0]  grant, ready, accept;
  logic              grant_any;
  logic [SrcW-1:0]   grant_idx;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_value;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_value_q;
  logic [SrcW-1:0]   cdb_src_q;

  // Distance of slot x from the pointer in circular search order.
  function automatic int unsigned rr_dist(int unsigned x, int unsigned p);
    return (x >= p) ? x - p : x + N_REQ - p;
  endfunction

  // Parallel search: slot i wins if no valid slot sits closer to the pointer.
  always_comb begin
    int unsigned ptr;
    ptr   = 32'(rr_ptr_q);
    grant = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant[i] = slot_valid_q[i] & ~bus.flush_i;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (j != i && slot_valid_q[j] && rr_dist(j, ptr) < rr_dist(i, ptr)) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant_any   = |grant;
    grant_idx   = '0;
    grant_tag   = '0;
    grant_value = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx   = SrcW'(i);
        grant_tag   = slot_tag_q[i];
        grant_value = slot_value_q[i];
      end
    end
  end

  always_comb begin
    ready        = {N_REQ{rst_n & ~bus.flush_i}} & (~slot_valid_q | grant);
    accept       = bus.req_valid_i & ready;
    slot_valid_d = accept | (slot_valid_q & ~grant);
    rr_ptr_d     = rr_ptr_q;
    if (grant_any) begin
      // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
      rr_ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + SrcW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
    end else if (bus.flush_i) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= grant_any;
      if (grant_any) begin
        cdb_tag_q   <= grant_tag;
        cdb_value_q <= grant_value;
        cdb_src_q   <= grant_idx;
      end
    end
  end

  // Slot payload needs no reset; accept is already gated by reset and flush.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_tag_q[i]   <= bus.req_tag_i[i*TAG_W +: TAG_W];
        slot_value_q[i] <= bus.req_value_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.cdb_valid_o = cdb_valid_q;
  assign bus.cdb_tag_o   = cdb_tag_q;
  assign bus.cdb_value_o = cdb_value_q;
  assign bus.cdb_src_o   = cdb_src_q;
endmodule
